// File: rtl/shape_record_queue_pkg.sv
// Shared types for the shape record queue: record layout, FSM states and
// a saturating counter helper.
package shape_record_queue_pkg;

  // Packed record width and field offsets within a FIFO word.
  localparam int REC_W    = 97;
  localparam int LAST_BIT = 96;
  localparam int SUM_LSB  = 64;
  localparam int XMAX_LSB = 48;
  localparam int YMAX_LSB = 32;
  localparam int XMIN_LSB = 16;
  localparam int YMIN_LSB = 0;

  // Record as stored in the FIFO; layout matches the offsets above.
  typedef struct packed {
    logic        last;
    logic [31:0] sum;
    logic [15:0] xMax;
    logic [15:0] yMax;
    logic [15:0] xMin;
    logic [15:0] yMin;
  } rec_t;

  // IDLE: no frame open, RUN: frame open, MARK: end-of-frame marker pending.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MARK = 2'd2
  } state_t;

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/shape_record_queue_if.sv
// Record stream from the queue to the downstream consumer.
// Handshake: the master holds RecValid and all Rec* fields stable until the
// cycle in which RecValid && RecReady is seen at a rising clk edge; that edge
// transfers exactly one record. RecReady may change freely.
interface shape_record_queue_if;
  logic        RecValid;
  logic        RecReady;
  logic        RecLast;
  logic [31:0] RecSum;
  logic [15:0] RecXMax;
  logic [15:0] RecYMax;
  logic [15:0] RecXMin;
  logic [15:0] RecYMin;

  modport master (
    output RecValid, RecLast, RecSum, RecXMax, RecYMax, RecXMin, RecYMin,
    input  RecReady
  );

  modport slave (
    input  RecValid, RecLast, RecSum, RecXMax, RecYMax, RecXMin, RecYMin,
    output RecReady
  );
endinterface

// File: rtl/shape_record_queue_sync_fifo_fwft.sv
// Generic synchronous first-word-fall-through FIFO. Pointers carry one extra
// wrap bit so full and empty are distinguished by the MSB compare.
module sync_fifo_fwft #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      din,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   free_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_V = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wrPtr;
  logic [DEPTH_LOG2:0] rdPtr;
  logic                full;
  logic                doWr;
  logic                doRd;

  assign empty    = (wrPtr == rdPtr);
  assign full     = (wrPtr[DEPTH_LOG2] != rdPtr[DEPTH_LOG2]) &&
                    (wrPtr[DEPTH_LOG2-1:0] == rdPtr[DEPTH_LOG2-1:0]);
  assign free_cnt = DEPTH_V - (wrPtr - rdPtr);
  assign doRd     = rd_en && !empty;
  // A write into a full FIFO is fine when the head leaves in the same cycle.
  assign doWr     = wr_en && (!full || doRd);
  assign dout     = mem[rdPtr[DEPTH_LOG2-1:0]];

  // Pointer update; pop and push in one cycle both advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doWr) wrPtr <= wrPtr + 1'b1;
      if (doRd) rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty gates the head.
  always_ff @(posedge clk) begin
    if (doWr) mem[wrPtr[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/shape_record_queue.sv
// Receives completed-shape records from the labeler, drops small shapes,
// queues survivors and closes every frame with an end-of-frame marker that
// carries the accepted count, dropped count and frame number.
module shape_record_queue
  import shape_record_queue_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 6,
  parameter logic [31:0] MIN_SUM    = 32'd4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Vsync,
  input  logic                  DataOutEn,
  input  logic [31:0]           SumO,
  input  logic [15:0]           XMaxO,
  input  logic [15:0]           YMaxO,
  input  logic [15:0]           XMinO,
  input  logic [15:0]           YMinO,
  shape_record_queue_if.master  recIf,
  output logic                  Overflow,
  output state_t                dbgState
);

  localparam logic [DEPTH_LOG2:0] ONE_V = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0] TWO_V = (DEPTH_LOG2 + 1)'(2);

  state_t              state;
  logic                vsyncD;
  logic                inEn;
  rec_t                inRec;
  logic                holdValid;
  rec_t                hold;
  logic [15:0]         accCnt;
  logic [15:0]         dropCnt;
  logic [15:0]         frameNum;

  logic                vsEdge;
  logic                inKeep;
  logic                markNow;
  logic                dataDue;
  logic                dataFits;
  logic                markFits;
  logic                loadHold;
  rec_t                dataSrc;
  rec_t                marker;
  logic                fifoWr;
  logic [REC_W-1:0]    fifoDin;
  logic [REC_W-1:0]    fifoDout;
  logic                fifoEmpty;
  logic [DEPTH_LOG2:0] freeCnt;
  logic                popNow;

  assign vsEdge   = Vsync && !vsyncD;
  assign inKeep   = inEn && (inRec.sum >= MIN_SUM);
  // A held record from before the close must go out ahead of the marker.
  assign markNow  = (state == ST_MARK) && !holdValid;
  assign dataDue  = !markNow && (holdValid || inKeep);
  assign dataSrc  = holdValid ? hold : inRec;
  // The last free slot stays reserved so a marker always has room.
  assign dataFits = (freeCnt >= TWO_V);
  assign markFits = (freeCnt >= ONE_V);
  // Incoming record parks in hold when the write port is taken this cycle.
  assign loadHold = inKeep && (markNow || holdValid);
  assign marker   = '{last: 1'b1, sum: {16'd0, accCnt}, xMax: dropCnt,
                      yMax: frameNum, xMin: 16'd0, yMin: 16'd0};
  assign fifoWr   = markNow ? markFits : (dataDue && dataFits);
  assign fifoDin  = markNow ? marker : dataSrc;
  assign popNow   = recIf.RecValid && recIf.RecReady;
  assign dbgState = state;

  sync_fifo_fwft #(
    .WIDTH      (REC_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (fifoWr),
    .din      (fifoDin),
    .rd_en    (popNow),
    .dout     (fifoDout),
    .empty    (fifoEmpty),
    .free_cnt (freeCnt)
  );

  // Head fields are forced to zero whenever nothing is queued.
  assign recIf.RecValid = !fifoEmpty;
  assign recIf.RecLast  = !fifoEmpty && fifoDout[LAST_BIT];
  assign recIf.RecSum   = fifoEmpty ? 32'd0 : fifoDout[SUM_LSB  +: 32];
  assign recIf.RecXMax  = fifoEmpty ? 16'd0 : fifoDout[XMAX_LSB +: 16];
  assign recIf.RecYMax  = fifoEmpty ? 16'd0 : fifoDout[YMAX_LSB +: 16];
  assign recIf.RecXMin  = fifoEmpty ? 16'd0 : fifoDout[XMIN_LSB +: 16];
  assign recIf.RecYMin  = fifoEmpty ? 16'd0 : fifoDout[YMIN_LSB +: 16];

  // Input capture, hold register, frame counters and the frame FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      vsyncD    <= 1'b0;
      inEn      <= 1'b0;
      inRec     <= '0;
      holdValid <= 1'b0;
      hold      <= '0;
      accCnt    <= 16'd0;
      dropCnt   <= 16'd0;
      frameNum  <= 16'd0;
      Overflow  <= 1'b0;
    end else begin
      vsyncD    <= Vsync;
      inEn      <= DataOutEn;
      inRec     <= '{last: 1'b0, sum: SumO, xMax: XMaxO, yMax: YMaxO,
                     xMin: XMinO, yMin: YMinO};
      holdValid <= loadHold;
      if (loadHold) hold <= inRec;

      if (markNow) begin
        accCnt   <= 16'd0;
        dropCnt  <= 16'd0;
        Overflow <= 1'b0;
        frameNum <= frameNum + 16'd1;
      end else if (dataDue) begin
        if (dataFits) begin
          accCnt <= satInc16(accCnt);
        end else begin
          dropCnt  <= satInc16(dropCnt);
          Overflow <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: if (vsEdge) state <= ST_RUN;
        ST_RUN:  if (vsEdge) state <= ST_MARK;
        ST_MARK: if (markNow) state <= ST_RUN;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shape_record_queue.sv
// Directed bench for shape_record_queue with a 4-entry FIFO.
module tb_shape_record_queue;
  import shape_record_queue_pkg::*;

  localparam int W = REC_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        Vsync;
  logic        DataOutEn;
  logic [31:0] SumO;
  logic [15:0] XMaxO;
  logic [15:0] YMaxO;
  logic [15:0] XMinO;
  logic [15:0] YMinO;
  logic        Overflow;
  state_t      dbgState;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  shape_record_queue_if recIf ();

  shape_record_queue #(
    .DEPTH_LOG2 (2),
    .MIN_SUM    (32'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Vsync     (Vsync),
    .DataOutEn (DataOutEn),
    .SumO      (SumO),
    .XMaxO     (XMaxO),
    .YMaxO     (YMaxO),
    .XMinO     (XMinO),
    .YMinO     (YMinO),
    .recIf     (recIf),
    .Overflow  (Overflow),
    .dbgState  (dbgState)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mkRec(input logic last, input logic [31:0] s,
                                         input logic [15:0] xa, input logic [15:0] ya,
                                         input logic [15:0] xi, input logic [15:0] yi);
    return {last, s, xa, ya, xi, yi};
  endfunction

  function automatic logic [W-1:0] headRec();
    return {recIf.RecLast, recIf.RecSum, recIf.RecXMax, recIf.RecYMax,
            recIf.RecXMin, recIf.RecYMin};
  endfunction

  task automatic sendRec(input logic [31:0] s, input logic [15:0] xa, input logic [15:0] ya,
                         input logic [15:0] xi, input logic [15:0] yi);
    DataOutEn = 1'b1;
    SumO = s; XMaxO = xa; YMaxO = ya; XMinO = xi; YMinO = yi;
    tick;
    DataOutEn = 1'b0;
  endtask

  task automatic pulseVsync;
    Vsync = 1'b1;
    tick;
    Vsync = 1'b0;
    tick;
  endtask

  task automatic popCheck(input string tag, input logic [W-1:0] exp);
    int n = 0;
    while (!recIf.RecValid && n < 50) begin
      tick;
      n++;
    end
    check({tag, " valid"}, recIf.RecValid, 1);
    check(tag, headRec(), exp);
    recIf.RecReady = 1'b1;
    tick;
    recIf.RecReady = 1'b0;
  endtask

  task automatic produceStream(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mkRec(1'b0, 32'(40 + i), 16'(i), 16'(i + 1), 16'(i + 2), 16'(i + 3)));
      sendRec(32'(40 + i), 16'(i), 16'(i + 1), 16'(i + 2), 16'(i + 3));
      tick;
    end
  endtask

  task automatic consumeStream(input int n);
    int got = 0;
    int cyc = 0;
    logic stallPrev = 1'b0;
    logic [W-1:0] saved = '0;
    while (got < n && cyc < 300) begin
      recIf.RecReady = ~recIf.RecReady;
      if (stallPrev) begin
        check("t4 stable", headRec(), saved);
        stallPrev = 1'b0;
      end
      if (recIf.RecValid) begin
        if (recIf.RecReady) begin
          if (exp_q.size() == 0) check("t4 extra", 1, 0);
          else check("t4 order", headRec(), exp_q.pop_front());
          got++;
        end else begin
          saved = headRec();
          stallPrev = 1'b1;
        end
      end
      tick;
      cyc++;
    end
    check("t4 count", got, n);
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1; Vsync = 1'b0; DataOutEn = 1'b0;
    SumO = '0; XMaxO = '0; YMaxO = '0; XMinO = '0; YMinO = '0;
    recIf.RecReady = 1'b0;

    // Reset state
    tick;
    check("rst valid", recIf.RecValid, 0);
    check("rst head", headRec(), 0);
    check("rst overflow", Overflow, 0);
    check("rst state", dbgState, ST_IDLE);
    rst = 1'b0;

    // 1: filter and marker
    pulseVsync;
    check("t1 state run", dbgState, ST_RUN);
    DataOutEn = 1'b1; SumO = 32'd10; XMaxO = 16'd11; YMaxO = 16'd12; XMinO = 16'd1; YMinO = 16'd2;
    tick;
    DataOutEn = 1'b0;
    check("t1 latency e0", recIf.RecValid, 0);
    tick;
    check("t1 latency e1", recIf.RecValid, 1);
    sendRec(32'd2, 16'd5, 16'd5, 16'd5, 16'd5);
    sendRec(32'd7, 16'd21, 16'd22, 16'd3, 16'd4);
    tick;
    pulseVsync;
    popCheck("t1 rec10", mkRec(1'b0, 32'd10, 16'd11, 16'd12, 16'd1, 16'd2));
    popCheck("t1 rec7", mkRec(1'b0, 32'd7, 16'd21, 16'd22, 16'd3, 16'd4));
    popCheck("t1 marker", mkRec(1'b1, 32'd2, 16'd0, 16'd0, 16'd0, 16'd0));
    check("t1 empty", recIf.RecValid, 0);

    // 2: overflow with one slot reserved for the marker
    for (int i = 0; i < 5; i++) sendRec(32'd5, 16'(i), 16'd0, 16'd0, 16'd0);
    tick;
    tick;
    check("t2 overflow set", Overflow, 1);
    pulseVsync;
    tick;
    check("t2 overflow clr", Overflow, 0);
    for (int i = 0; i < 3; i++) popCheck("t2 rec", mkRec(1'b0, 32'd5, 16'(i), 16'd0, 16'd0, 16'd0));
    popCheck("t2 marker", mkRec(1'b1, 32'd3, 16'd2, 16'd1, 16'd0, 16'd0));

    // 3: record in the Vsync edge cycle lands after the marker
    sendRec(32'd20, 16'd1, 16'd1, 16'd1, 16'd1);
    Vsync = 1'b1; DataOutEn = 1'b1;
    SumO = 32'd30; XMaxO = 16'd3; YMaxO = 16'd3; XMinO = 16'd3; YMinO = 16'd3;
    tick;
    Vsync = 1'b0; DataOutEn = 1'b0;
    check("t3 state mark", dbgState, ST_MARK);
    tick;
    check("t3 state run", dbgState, ST_RUN);
    tick;
    tick;
    pulseVsync;
    popCheck("t3 recA", mkRec(1'b0, 32'd20, 16'd1, 16'd1, 16'd1, 16'd1));
    popCheck("t3 marker1", mkRec(1'b1, 32'd1, 16'd0, 16'd2, 16'd0, 16'd0));
    popCheck("t3 recB", mkRec(1'b0, 32'd30, 16'd3, 16'd3, 16'd3, 16'd3));
    popCheck("t3 marker2", mkRec(1'b1, 32'd1, 16'd0, 16'd3, 16'd0, 16'd0));

    // 4: stream with RecReady toggling every cycle
    fork
      produceStream(10);
      consumeStream(10);
    join
    recIf.RecReady = 1'b0;
    tick;
    check("t4 queue drained", exp_q.size(), 0);
    check("t4 empty", recIf.RecValid, 0);

    // 5: reset with four entries queued
    for (int i = 0; i < 3; i++) sendRec(32'd8, 16'(i), 16'd0, 16'd0, 16'd0);
    tick;
    pulseVsync;
    tick;
    check("t5 queued", recIf.RecValid, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t5 rst valid", recIf.RecValid, 0);
    check("t5 rst head", headRec(), 0);
    check("t5 rst state", dbgState, ST_IDLE);
    pulseVsync;
    tick;
    tick;
    check("t5 no marker", recIf.RecValid, 0);
    check("t5 state run", dbgState, ST_RUN);
    sendRec(32'd9, 16'd7, 16'd7, 16'd7, 16'd7);
    tick;
    pulseVsync;
    popCheck("t5 rec9", mkRec(1'b0, 32'd9, 16'd7, 16'd7, 16'd7, 16'd7));
    popCheck("t5 marker", mkRec(1'b1, 32'd1, 16'd0, 16'd0, 16'd0, 16'd0));

    // 6: accepted count saturates
    recIf.RecReady = 1'b1;
    DataOutEn = 1'b1;
    SumO = 32'd100; YMaxO = 16'd0; XMinO = 16'd0; YMinO = 16'd0;
    for (int i = 0; i < 65537; i++) begin
      XMaxO = 16'(i);
      tick;
    end
    DataOutEn = 1'b0;
    tick;
    tick;
    tick;
    recIf.RecReady = 1'b0;
    check("t6 drained", recIf.RecValid, 0);
    check("t6 no overflow", Overflow, 0);
    pulseVsync;
    popCheck("t6 marker", mkRec(1'b1, 32'h0000FFFF, 16'd0, 16'd1, 16'd0, 16'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
